// File: rtl/operand_fetch_pkg.sv
// operand_pkg: shared constants for the operand fetch stage.
//   XLEN, NREG, AW : default datapath width, register count, index width
//   ALU_*          : ALU operation codes carried through to execute
package operand_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-side, write-back and execute-side signals of the
// operand fetch stage.
//   master : driven by decode / write-back, observes the pipeline register
//   slave  : the operand_fetch block itself
// Decode inputs  : InValid, Stall, Flush, Rs1, Rs2, Rd, ALUOpIn, ALUSrc, Imm
// Write-back     : RegWrite, WbRd, WbData
// Execute outputs: A, B, StoreData, ALUOp, RdOut, OutValid
interface operand_fetch_if #(
  parameter int XLEN = operand_pkg::XLEN,
  parameter int AW   = operand_pkg::AW
);

  logic            InValid;
  logic            Stall;
  logic            Flush;
  logic [AW-1:0]   Rs1;
  logic [AW-1:0]   Rs2;
  logic [AW-1:0]   Rd;
  logic [2:0]      ALUOpIn;
  logic            ALUSrc;
  logic [XLEN-1:0] Imm;

  logic            RegWrite;
  logic [AW-1:0]   WbRd;
  logic [XLEN-1:0] WbData;

  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [XLEN-1:0] StoreData;
  logic [2:0]      ALUOp;
  logic [AW-1:0]   RdOut;
  logic            OutValid;

  modport master (
    output InValid, Stall, Flush, Rs1, Rs2, Rd, ALUOpIn, ALUSrc, Imm,
    output RegWrite, WbRd, WbData,
    input  A, B, StoreData, ALUOp, RdOut, OutValid
  );

  modport slave (
    input  InValid, Stall, Flush, Rs1, Rs2, Rd, ALUOpIn, ALUSrc, Imm,
    input  RegWrite, WbRd, WbData,
    output A, B, StoreData, ALUOp, RdOut, OutValid
  );

endinterface

// File: rtl/operand_fetch_reg_file.sv
// reg_file: NREG x XLEN integer register file, 2 combinational read ports,
// 1 synchronous write port. x0 is hard-wired to zero.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a same-cycle write to a read index is forwarded to the read
//   undefined : reads return the pre-write contents
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears all registers)
//   ra1, ra2   : read indices;  rd1, rd2 : read data
//   we, wa, wd : write enable, write index, write data
module reg_file #(
  parameter int XLEN = operand_pkg::XLEN,
  parameter int NREG = operand_pkg::NREG,
  parameter int AW   = operand_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_en;

  // x0 writes are dropped here so regs[0] stays zero forever.
  assign wr_en = we && (wa != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) begin
      rd1 = (wr_en && (wa == ra1)) ? wd : regs[ra1];
    end
    if (ra2 != '0) begin
      rd2 = (wr_en && (wa == ra2)) ? wd : regs[ra2];
    end
  end
`else
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) begin
      rd1 = regs[ra1];
    end
    if (ra2 != '0) begin
      rd2 = regs[ra2];
    end
  end
`endif

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute stage feeding the ALU. Reads rs1/rs2 from
// the register file, selects B (register or immediate) and registers the
// operands, op code and destination tag into a one-deep pipeline register.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read
// forwarding inside reg_file).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : operand_fetch_if.slave (decode inputs, write-back port, ALU-side
//         registered outputs)
module operand_fetch #(
  parameter int XLEN = operand_pkg::XLEN,
  parameter int NREG = operand_pkg::NREG,
  parameter int AW   = operand_pkg::AW
) (
  input  logic           clk,
  input  logic           rst,
  operand_fetch_if.slave bus
);

  import operand_pkg::*;

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] b_sel;

  reg_file #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (bus.Rs1),
    .ra2 (bus.Rs2),
    .rd1 (rs1_data),
    .rd2 (rs2_data),
    .we  (bus.RegWrite),
    .wa  (bus.WbRd),
    .wd  (bus.WbData)
  );

  assign b_sel = bus.ALUSrc ? bus.Imm : rs2_data;

  // Priority Flush > Stall > load. Bubbles zero the data so that the
  // ALU sees a harmless ADD of 0+0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.OutValid  <= 1'b0;
      bus.A         <= '0;
      bus.B         <= '0;
      bus.StoreData <= '0;
      bus.ALUOp     <= ALU_ADD;
      bus.RdOut     <= '0;
    end else if (bus.Flush) begin
      bus.OutValid  <= 1'b0;
      bus.A         <= '0;
      bus.B         <= '0;
      bus.StoreData <= '0;
      bus.ALUOp     <= ALU_ADD;
      bus.RdOut     <= '0;
    end else if (!bus.Stall) begin
      bus.OutValid <= bus.InValid;
      if (bus.InValid) begin
        bus.A         <= rs1_data;
        bus.B         <= b_sel;
        bus.StoreData <= rs2_data;
        bus.ALUOp     <= bus.ALUOpIn;
        bus.RdOut     <= bus.Rd;
      end else begin
        bus.A         <= '0;
        bus.B         <= '0;
        bus.StoreData <= '0;
        bus.ALUOp     <= ALU_ADD;
        bus.RdOut     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.InValid  = 1'b0;
    bus.Stall    = 1'b0;
    bus.Flush    = 1'b0;
    bus.Rs1      = '0;
    bus.Rs2      = '0;
    bus.Rd       = '0;
    bus.ALUOpIn  = 3'b000;
    bus.ALUSrc   = 1'b0;
    bus.Imm      = '0;
    bus.RegWrite = 1'b0;
    bus.WbRd     = '0;
    bus.WbData   = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #3;
    n_checks++;
    if (bus.OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid got %0b want 0", bus.OutValid); end
    n_checks++;
    if (bus.A !== 32'h0 || bus.B !== 32'h0 || bus.StoreData !== 32'h0) begin
      n_fail++; $display("FAIL reset_data got A=%h B=%h SD=%h want 0", bus.A, bus.B, bus.StoreData);
    end
    n_checks++;
    if (bus.ALUOp !== 3'b000 || bus.RdOut !== 5'd0) begin
      n_fail++; $display("FAIL reset_op got op=%b rd=%0d want 0", bus.ALUOp, bus.RdOut);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstream();
    idle();
    bus.RegWrite = 1'b1; bus.WbRd = 5'd5; bus.WbData = 32'h55;
    tick();
    idle();
    bus.InValid = 1'b1; bus.Rs1 = 5'd5; bus.Rs2 = 5'd5;
    tick();
    n_checks++;
    if (bus.OutValid !== 1'b1 || bus.A !== 32'h55) begin
      n_fail++; $display("FAIL pre_reset_load got v=%0b A=%h want 1 00000055", bus.OutValid, bus.A);
    end
    #2;
    rst = 1'b1;
    bus.RegWrite = 1'b1; bus.WbRd = 5'd5; bus.WbData = 32'h77;
    #1;
    n_checks++;
    if (bus.OutValid !== 1'b0 || bus.A !== 32'h0 || bus.B !== 32'h0) begin
      n_fail++; $display("FAIL async_reset got v=%0b A=%h B=%h want 0", bus.OutValid, bus.A, bus.B);
    end
    tick();
    rst = 1'b0;
    idle();
    bus.InValid = 1'b1; bus.Rs1 = 5'd5; bus.Rs2 = 5'd5;
    tick();
    n_checks++;
    if (bus.A !== 32'h0 || bus.StoreData !== 32'h0 || bus.OutValid !== 1'b1) begin
      n_fail++; $display("FAIL x5_after_reset got A=%h SD=%h v=%0b want 0 0 1", bus.A, bus.StoreData, bus.OutValid);
    end
  endtask

  task automatic test_write_read();
    idle();
    bus.RegWrite = 1'b1; bus.WbRd = 5'd3; bus.WbData = 32'h0000_00AA;
    tick();
    idle();
    bus.InValid = 1'b1; bus.Rs1 = 5'd3; bus.Rs2 = 5'd3; bus.ALUOpIn = 3'b001; bus.Rd = 5'd4;
    tick();
    n_checks++;
    if (bus.A !== 32'hAA || bus.B !== 32'hAA) begin
      n_fail++; $display("FAIL read_x3 got A=%h B=%h want 000000aa", bus.A, bus.B);
    end
    n_checks++;
    if (bus.ALUOp !== 3'b001 || bus.RdOut !== 5'd4 || bus.OutValid !== 1'b1) begin
      n_fail++; $display("FAIL read_x3_ctrl got op=%b rd=%0d v=%0b want 001 4 1", bus.ALUOp, bus.RdOut, bus.OutValid);
    end
  endtask

  task automatic test_x0();
    idle();
    bus.RegWrite = 1'b1; bus.WbRd = 5'd0; bus.WbData = 32'hFFFF_FFFF;
    tick();
    idle();
    bus.InValid = 1'b1; bus.Rs1 = 5'd0; bus.Rs2 = 5'd0;
    tick();
    n_checks++;
    if (bus.A !== 32'h0 || bus.StoreData !== 32'h0) begin
      n_fail++; $display("FAIL x0_zero got A=%h SD=%h want 0", bus.A, bus.StoreData);
    end
  endtask

  task automatic test_imm();
    idle();
    bus.InValid = 1'b1; bus.Rs1 = 5'd3; bus.Rs2 = 5'd3; bus.ALUSrc = 1'b1;
    bus.Imm = 32'hFFFF_FFF0; bus.ALUOpIn = 3'b100; bus.Rd = 5'd12;
    tick();
    n_checks++;
    if (bus.B !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL imm_b got %h want fffffff0", bus.B); end
    n_checks++;
    if (bus.StoreData !== 32'hAA || bus.A !== 32'hAA) begin
      n_fail++; $display("FAIL imm_storedata got SD=%h A=%h want 000000aa", bus.StoreData, bus.A);
    end
  endtask

  task automatic test_stall_flush();
    idle();
    bus.InValid = 1'b1; bus.Rs1 = 5'd3; bus.Rs2 = 5'd3; bus.ALUOpIn = 3'b010; bus.Rd = 5'd9;
    tick();
    // Stall with changing inputs and a write-back to the held source.
    bus.Stall = 1'b1; bus.Rs1 = 5'd0; bus.ALUSrc = 1'b1; bus.Imm = 32'h1111_2222;
    bus.ALUOpIn = 3'b011; bus.Rd = 5'd1;
    bus.RegWrite = 1'b1; bus.WbRd = 5'd3; bus.WbData = 32'hBB;
    tick();
    bus.RegWrite = 1'b0; bus.InValid = 1'b0; bus.Rs2 = 5'd0;
    n_checks++;
    if (bus.A !== 32'hAA || bus.B !== 32'hAA || bus.ALUOp !== 3'b010 || bus.RdOut !== 5'd9 || bus.OutValid !== 1'b1) begin
      n_fail++; $display("FAIL stall_c1 got A=%h B=%h op=%b rd=%0d v=%0b want aa aa 010 9 1", bus.A, bus.B, bus.ALUOp, bus.RdOut, bus.OutValid);
    end
    tick();
    n_checks++;
    if (bus.A !== 32'hAA || bus.StoreData !== 32'hAA || bus.OutValid !== 1'b1) begin
      n_fail++; $display("FAIL stall_c2 got A=%h SD=%h v=%0b want aa aa 1", bus.A, bus.StoreData, bus.OutValid);
    end
    bus.Flush = 1'b1; bus.InValid = 1'b1;
    bus.RegWrite = 1'b1; bus.WbRd = 5'd8; bus.WbData = 32'h88;
    tick();
    n_checks++;
    if (bus.OutValid !== 1'b0 || bus.A !== 32'h0 || bus.RdOut !== 5'd0 || bus.ALUOp !== 3'b000) begin
      n_fail++; $display("FAIL flush got v=%0b A=%h rd=%0d op=%b want 0", bus.OutValid, bus.A, bus.RdOut, bus.ALUOp);
    end
    idle();
    bus.InValid = 1'b1; bus.Rs1 = 5'd3; bus.Rs2 = 5'd8;
    tick();
    n_checks++;
    if (bus.A !== 32'hBB || bus.B !== 32'h88) begin
      n_fail++; $display("FAIL wb_not_gated got A=%h B=%h want bb 88", bus.A, bus.B);
    end
  endtask

  task automatic test_bubble();
    idle();
    bus.InValid = 1'b1; bus.Rs1 = 5'd3; bus.Rs2 = 5'd3; bus.ALUOpIn = 3'b011; bus.Rd = 5'd6;
    tick();
    bus.InValid = 1'b0;
    tick();
    n_checks++;
    if (bus.OutValid !== 1'b0 || bus.A !== 32'h0 || bus.B !== 32'h0 || bus.StoreData !== 32'h0 || bus.ALUOp !== 3'b000 || bus.RdOut !== 5'd0) begin
      n_fail++; $display("FAIL bubble got v=%0b A=%h B=%h SD=%h op=%b rd=%0d want 0", bus.OutValid, bus.A, bus.B, bus.StoreData, bus.ALUOp, bus.RdOut);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a;
    idle();
    bus.InValid = 1'b1; bus.Rs1 = 5'd7; bus.Rs2 = 5'd7;
    bus.RegWrite = 1'b1; bus.WbRd = 5'd7; bus.WbData = 32'h1234;
`ifdef REGFILE_BYPASS_EN
    exp_a = 32'h1234;
`else
    exp_a = 32'h0;
`endif
    tick();
    n_checks++;
    if (bus.A !== exp_a || bus.StoreData !== exp_a) begin
      n_fail++; $display("FAIL same_cycle_wb got A=%h SD=%h want %h", bus.A, bus.StoreData, exp_a);
    end
    bus.RegWrite = 1'b0;
    tick();
    n_checks++;
    if (bus.A !== 32'h1234 || bus.B !== 32'h1234) begin
      n_fail++; $display("FAIL x7_next got A=%h B=%h want 00001234", bus.A, bus.B);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_reset_midstream();
    test_write_read();
    test_x0();
    test_imm();
    test_stall_flush();
    test_bubble();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
